// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and the write-back requester index.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LD  = 1'b1
    } wb_src_e;

    // x0 is hardwired, so it can never be a hazard source.
    function automatic logic reg_busy(input logic [NUM_REGS-1:0]   mask,
                                      input logic [REG_ADDR_W-1:0] addr);
        return (addr != '0) && mask[addr];
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue/check, write-back request and register-file port bundle.
interface regfile_wb_scheduler_if;
    import riscv_pkg::*;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic [REG_ADDR_W-1:0] chk_rd;
    logic                  hazard;
    logic [NUM_REGS-1:0]   busy_mask;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;

    logic                  regWrite;
    logic [REG_ADDR_W-1:0] writeRegister;
    logic [XLEN-1:0]       writeData;

    modport master (
        output issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  hazard, busy_mask, alu_ready, ld_ready,
        input  regWrite, writeRegister, writeData
    );

    modport slave (
        input  issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output hazard, busy_mask, alu_ready, ld_ready,
        output regWrite, writeRegister, writeData
    );

endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - 2-way write-back grant; WB_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed load-over-ALU priority with no pointer flop.
module wb_arbiter2
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_alu_valid,
    input  logic i_ld_valid,
    output logic o_alu_grant,
    output logic o_ld_grant
);

`ifdef WB_ROUND_ROBIN_EN
    wb_src_e r_last;
    logic    w_pref_ld;

    assign w_pref_ld = (r_last == WB_SRC_ALU);

    always_comb begin
        o_ld_grant  = i_ld_valid && (!i_alu_valid || w_pref_ld);
        o_alu_grant = i_alu_valid && !o_ld_grant;
    end

    // Reset value makes the ALU the preferred side for the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= WB_SRC_LD;
        end else if (o_ld_grant) begin
            r_last <= WB_SRC_LD;
        end else if (o_alu_grant) begin
            r_last <= WB_SRC_ALU;
        end
    end
`else
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clk ^ rst_n;

    always_comb begin
        o_ld_grant  = i_ld_valid;
        o_alu_grant = i_alu_valid && !i_ld_valid;
    end
`endif

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - shares the register-file write port between ALU and load,
// and keeps the per-register busy scoreboard; arbitration policy via WB_ROUND_ROBIN_EN.
module regfile_wb_scheduler
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave wb
);

    logic                  w_alu_grant;
    logic                  w_ld_grant;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_data;
    logic [NUM_REGS-1:0]   w_busy_next;

    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_wr;
    logic [XLEN-1:0]       r_wd;

    wb_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alu_valid (wb.alu_valid),
        .i_ld_valid  (wb.ld_valid),
        .o_alu_grant (w_alu_grant),
        .o_ld_grant  (w_ld_grant)
    );

    assign wb.alu_ready = w_alu_grant;
    assign wb.ld_ready  = w_ld_grant;

    assign w_xfer = w_alu_grant || w_ld_grant;
    assign w_rd   = w_ld_grant ? wb.ld_rd   : wb.alu_rd;
    assign w_data = w_ld_grant ? wb.ld_data : wb.alu_data;

    // Clear first, then set: a same-edge issue to the committing register keeps it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) begin
            w_busy_next[r_wr] = 1'b0;
        end
        if (wb.issue_valid && (wb.issue_rd != '0)) begin
            w_busy_next[wb.issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_we   <= 1'b0;
            r_wr   <= '0;
            r_wd   <= '0;
        end else begin
            r_busy <= w_busy_next;
            r_we   <= w_xfer && (w_rd != '0);
            if (w_xfer) begin
                r_wr <= w_rd;
                r_wd <= w_data;
            end
        end
    end

    assign wb.hazard = reg_busy(r_busy, wb.chk_rs1) ||
                       reg_busy(r_busy, wb.chk_rs2) ||
                       reg_busy(r_busy, wb.chk_rd);

    assign wb.busy_mask     = r_busy;
    assign wb.regWrite      = r_we;
    assign wb.writeRegister = r_wr;
    assign wb.writeData     = r_wd;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler (either WB_ROUND_ROBIN_EN build).
module tb_regfile_wb_scheduler;
    import riscv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] busy;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        m_last_ld;
    logic        g_alu;
    logic        g_ld;

    logic [31:0] rf_dut [32] = '{default: 32'h0};

    // Register file fed by the DUT write port.
    always @(posedge clk) begin
        if (bus.regWrite) rf_dut[bus.writeRegister] <= bus.writeData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycle(input logic iv, input logic [4:0] ird,
                         input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] c3);
        exp_t        e;
        logic        hz;
        logic [4:0]  rd;
        logic [31:0] d;
        @(negedge clk);
        bus.issue_valid = iv;  bus.issue_rd = ird;
        bus.alu_valid   = av;  bus.alu_rd   = ard; bus.alu_data = adat;
        bus.ld_valid    = lv;  bus.ld_rd    = lrd; bus.ld_data  = ldat;
        bus.chk_rs1 = c1; bus.chk_rs2 = c2; bus.chk_rd = c3;
        #1;
        hz = (c1 != 0 && m_busy[c1]) || (c2 != 0 && m_busy[c2]) || (c3 != 0 && m_busy[c3]);
        check("hazard", {31'b0, bus.hazard}, {31'b0, hz});
        if (av && lv) begin
`ifdef WB_ROUND_ROBIN_EN
            g_ld = !m_last_ld;
`else
            g_ld = 1'b1;
`endif
        end else begin
            g_ld = lv;
        end
        g_alu = av && !g_ld;
        check("alu_ready", {31'b0, bus.alu_ready}, {31'b0, g_alu});
        check("ld_ready",  {31'b0, bus.ld_ready},  {31'b0, g_ld});
        if (m_we) m_busy[m_wr] = 1'b0;
        if (iv && ird != 0) m_busy[ird] = 1'b1;
        if (g_alu || g_ld) begin
            rd = g_ld ? lrd : ard;
            d  = g_ld ? ldat : adat;
            m_we = (rd != 0);
            m_wr = rd;
            m_wd = d;
            m_last_ld = g_ld;
        end else begin
            m_we = 1'b0;
        end
        e.we = m_we; e.wr = m_wr; e.wd = m_wd; e.busy = m_busy;
        q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] c1);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, c1, 5'd0, 5'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("regWrite",      {31'b0, bus.regWrite},      {31'b0, e.we});
                check("writeRegister", {27'b0, bus.writeRegister}, {27'b0, e.wr});
                check("writeData",     bus.writeData,              e.wd);
                check("busy_mask",     bus.busy_mask,              e.busy);
            end
        end
    end

    initial begin : stim
        logic        ap, lp;
        logic [4:0]  ard, lrd, ird, c1, c2, c3;
        logic [31:0] adat, ldat;
        logic        iv;

        m_busy = '0; m_we = 1'b0; m_wr = '0; m_wd = '0; m_last_ld = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAAAA_0003;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd4; bus.ld_data  = 32'hBBBB_0004;
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_regWrite",      {31'b0, bus.regWrite},      32'd0);
        check("rst_writeRegister", {27'b0, bus.writeRegister}, 32'd0);
        check("rst_writeData",     bus.writeData,              32'd0);
        check("rst_busy_mask",     bus.busy_mask,              32'd0);
        check("rst_no_rf_write",   rf_dut[3] | rf_dut[4],      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;

        // Issue rd=5, then ALU writes it back.
        cycle(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0);
        idle(5'd5);
        idle(5'd5);
        check("rf5_deadbeef", rf_dut[5], 32'hDEADBEEF);

        // Contention for 4 cycles, then let any stalled ALU request finish.
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 5'd0, 1'b1, 5'd10, 32'h0A0A_0A0A, 1'b1, 5'd11, 32'h0B0B_0B0B, 5'd10, 5'd11, 5'd0);
        cycle(1'b0, 5'd0, 1'b1, 5'd10, 32'h0A0A_0A0A, 1'b0, 5'd0, 32'h0, 5'd10, 5'd11, 5'd0);

        // Load to x0.
        cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 5'd0);

        // Set/clear collision on register 7.
        cycle(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0);
        cycle(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0);
        idle(5'd7);
        check("collision_busy7", {31'b0, bus.busy_mask[7]}, 32'd1);

        // Randomised traffic; pending requests are held until accepted.
        ap = 1'b0; lp = 1'b0;
        ard = '0; lrd = '0; adat = '0; ldat = '0;
        for (int k = 0; k < 300; k++) begin
            if (!ap && $urandom_range(0, 1) == 1) begin
                ap = 1'b1; ard = 5'($urandom_range(0, 31)); adat = $urandom;
            end
            if (!lp && $urandom_range(0, 1) == 1) begin
                lp = 1'b1; lrd = 5'($urandom_range(0, 31)); ldat = $urandom;
            end
            iv  = ($urandom_range(0, 2) == 0);
            ird = 5'($urandom_range(0, 31));
            c1  = 5'($urandom_range(0, 31));
            c2  = 5'($urandom_range(0, 31));
            c3  = 5'($urandom_range(0, 31));
            cycle(iv, ird, ap, ard, adat, lp, lrd, ldat, c1, c2, c3);
            if (g_alu) ap = 1'b0;
            if (g_ld)  lp = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 5'd0, ap, ard, adat, lp, lrd, ldat, 5'd0, 5'd0, 5'd0);
            if (g_alu) ap = 1'b0;
            if (g_ld)  lp = 1'b0;
        end

        // Sweep: issue and write back rd=i, data=i.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 5'(i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'd0, 5'd0);
            cycle(1'b0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0, 5'(i), 5'd0, 5'd0);
        end
        idle(5'd0);
        idle(5'd0);
        @(posedge clk);
        #2;

        check("final_busy_mask", bus.busy_mask, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("rf[%0d]", i), rf_dut[i], 32'(i));
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
